// File: rtl/encoder_ctrl.sv
// -----------------------------------------------------------------------------
// encoder_ctrl
//
// Sequencer for the zero-skipping brick encoder. It accepts one brick-encode
// request per filter window and enables the encoder for the conversion. When
// the encoder flags that its result is ready, the sequencer writes the packed
// value brick and then the offset brick back to neuron memory (NM). It then
// drops the encoder enable for one cycle, which returns the encoder to its
// first state, before it accepts the next request.
//
// Optional feature macro: ENC_CTRL_STATS_EN
//   When defined, the stat_bricks and stat_timeouts counter ports are added.
//   When undefined, those ports and counters are absent and the behaviour is
//   otherwise identical.
//
// Parameters
//   ADDR_W    NM address width
//   OFF_ADDR  offset added to the brick address for the offset-brick write
//             (wraps modulo 2^ADDR_W)
//   TIMEOUT   maximum number of ENCODE cycles before the request is aborted
//             (must be >= 17 and < 256)
//
// Ports
//   clk             system clock
//   rst             synchronous, active-high reset
//   brick_valid     request to encode the brick at the encoder inputs
//   brick_ready     controller can accept a request (state == IDLE)
//   brick_addr      NM address of the value brick, sampled on handshake
//   enc_en          encoder enable; low returns the encoder to its first state
//   enc_data_ready  encoder result (packed brick + offsets) valid and held
//   nm_wr_en        NM write request, held until acknowledged
//   nm_wr_sel       0 = value brick, 1 = offset brick
//   nm_wr_addr      NM write address
//   nm_wr_ack       NM accepted the write this cycle
//   busy            high in any state other than IDLE
//   done            one-cycle pulse when a brick is fully written back
//   err_timeout     sticky; the encoder never flagged ready in time
//   stat_bricks     (stats build) completed bricks, saturating
//   stat_timeouts   (stats build) timeout aborts, saturating
// -----------------------------------------------------------------------------
module encoder_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int OFF_ADDR = 256,
  parameter int TIMEOUT  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              brick_valid,
  output logic              brick_ready,
  input  logic [ADDR_W-1:0] brick_addr,
  output logic              enc_en,
  input  logic              enc_data_ready,
  output logic              nm_wr_en,
  output logic              nm_wr_sel,
  output logic [ADDR_W-1:0] nm_wr_addr,
  input  logic              nm_wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
`ifdef ENC_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_bricks,
  output logic [7:0]        stat_timeouts
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENCODE  = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_OFF  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Offset truncated to the address width so the sum wraps naturally.
  localparam logic [ADDR_W-1:0] OFF_ADDR_W = OFF_ADDR[ADDR_W-1:0];
  localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT - 1);

  logic [2:0]        state_reg,   state_next;
  logic              enc_en_reg,  enc_en_next;
  logic              wr_en_reg,   wr_en_next;
  logic              wr_sel_reg,  wr_sel_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic              done_reg,    done_next;
  logic              err_reg,     err_next;
  logic [7:0]        cnt_reg,     cnt_next;
  logic [ADDR_W-1:0] addr_reg,    addr_next;

  always_comb begin
    state_next   = state_reg;
    enc_en_next  = enc_en_reg;
    wr_en_next   = wr_en_reg;
    wr_sel_next  = wr_sel_reg;
    wr_addr_next = wr_addr_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (brick_valid) begin
          addr_next   = brick_addr;
          cnt_next    = 8'd0;
          enc_en_next = 1'b1;
          state_next  = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        cnt_next = cnt_reg + 8'd1;
        // A ready flag wins over a timeout that lands in the same cycle.
        if (enc_data_ready) begin
          wr_en_next   = 1'b1;
          wr_sel_next  = 1'b0;
          wr_addr_next = addr_reg;
          state_next   = ST_WR_DATA;
        end else if (cnt_reg == TO_LAST) begin
          err_next    = 1'b1;
          enc_en_next = 1'b0;
          state_next  = ST_RELEASE;
        end
      end
      ST_WR_DATA: begin
        // enc_en stays high so the encoder keeps holding its outputs.
        if (nm_wr_ack) begin
          wr_sel_next  = 1'b1;
          wr_addr_next = addr_reg + OFF_ADDR_W;
          state_next   = ST_WR_OFF;
        end
      end
      ST_WR_OFF: begin
        if (nm_wr_ack) begin
          wr_en_next  = 1'b0;
          enc_en_next = 1'b0;
          done_next   = 1'b1;
          state_next  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // One cycle with enc_en low lets the encoder reset to its first state.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      enc_en_reg  <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_sel_reg  <= 1'b0;
      wr_addr_reg <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cnt_reg     <= 8'd0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      enc_en_reg  <= enc_en_next;
      wr_en_reg   <= wr_en_next;
      wr_sel_reg  <= wr_sel_next;
      wr_addr_reg <= wr_addr_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
    end
  end

  assign brick_ready = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign enc_en      = enc_en_reg;
  assign nm_wr_en    = wr_en_reg;
  assign nm_wr_sel   = wr_sel_reg;
  assign nm_wr_addr  = wr_addr_reg;
  assign done        = done_reg;
  assign err_timeout = err_reg;

`ifdef ENC_CTRL_STATS_EN
  logic [15:0] bricks_reg;
  logic [7:0]  timeouts_reg;

  // The events are decoded from the current state so they line up with the
  // transitions that raise done and err_timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bricks_reg   <= 16'd0;
      timeouts_reg <= 8'd0;
    end else begin
      if (state_reg == ST_WR_OFF && nm_wr_ack && bricks_reg != 16'hFFFF)
        bricks_reg <= bricks_reg + 16'd1;
      if (state_reg == ST_ENCODE && !enc_data_ready && cnt_reg == TO_LAST &&
          timeouts_reg != 8'hFF)
        timeouts_reg <= timeouts_reg + 8'd1;
    end
  end

  assign stat_bricks   = bricks_reg;
  assign stat_timeouts = timeouts_reg;
`endif

endmodule

// File: tb/tb_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encoder_ctrl
//
// Directed bench for encoder_ctrl. It contains a behavioural encoder that
// raises its ready flag after enc_en has been high for 16 sampled edges, and
// an NM model that acknowledges each write after a programmable wait. It runs
// a table of single-brick vectors, followed by hand-written timeout, reset and
// back-to-back sequences.
// -----------------------------------------------------------------------------
module tb_encoder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        brick_valid;
  logic        brick_ready;
  logic [11:0] brick_addr;
  logic        enc_en;
  logic        enc_data_ready;
  logic        nm_wr_en;
  logic        nm_wr_sel;
  logic [11:0] nm_wr_addr;
  logic        nm_wr_ack;
  logic        busy;
  logic        done;
  logic        err_timeout;
`ifdef ENC_CTRL_STATS_EN
  logic [15:0] stat_bricks;
  logic [7:0]  stat_timeouts;
`endif

  always #5 clk = ~clk;

  encoder_ctrl #(.ADDR_W(12), .OFF_ADDR(256), .TIMEOUT(20)) dut (
    .clk            (clk),
    .rst            (rst),
    .brick_valid    (brick_valid),
    .brick_ready    (brick_ready),
    .brick_addr     (brick_addr),
    .enc_en         (enc_en),
    .enc_data_ready (enc_data_ready),
    .nm_wr_en       (nm_wr_en),
    .nm_wr_sel      (nm_wr_sel),
    .nm_wr_addr     (nm_wr_addr),
    .nm_wr_ack      (nm_wr_ack),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout)
`ifdef ENC_CTRL_STATS_EN
    ,
    .stat_bricks    (stat_bricks),
    .stat_timeouts  (stat_timeouts)
`endif
  );

  // Encoder model: ready once enc_en has been high for 16 sampled edges.
  int   enc_cnt = 0;
  logic enc_ok  = 1'b1;
  always @(posedge clk) begin
    if (enc_en !== 1'b1) enc_cnt <= 0;
    else if (enc_cnt < 1000) enc_cnt <= enc_cnt + 1;
  end
  assign enc_data_ready = enc_ok && (enc_en === 1'b1) && (enc_cnt >= 16);

  // NM model: acknowledges after ack_delay cycles of a pending request.
  int ack_delay = 0;
  int wcnt = 0;
  always @(posedge clk) begin
    if (nm_wr_en !== 1'b1 || nm_wr_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign nm_wr_ack = (nm_wr_en === 1'b1) && (wcnt >= ack_delay);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  int          nw, ndone, nhs, to_cyc, enc_hi, wen_hi, unstable;
  logic        wsel  [4];
  logic [11:0] waddr [4];
  int          done_cyc [4];
  int          hs_cyc   [4];
  logic        prev_pending;
  logic        prev_sel;
  logic [11:0] prev_addr;

  task automatic clear_mon();
    nw = 0; ndone = 0; nhs = 0; to_cyc = -1; enc_hi = 0; wen_hi = 0;
    unstable = 0; prev_pending = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wsel[i] = 1'b0; waddr[i] = '0; done_cyc[i] = -1; hs_cyc[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (nm_wr_en === 1'b1 && nm_wr_ack && nw < 4) begin
      wsel[nw] = nm_wr_sel; waddr[nw] = nm_wr_addr; nw++;
    end
    if (done === 1'b1 && ndone < 4) begin done_cyc[ndone] = cyc; ndone++; end
    if (err_timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
    if (enc_en === 1'b1) enc_hi++;
    if (nm_wr_en === 1'b1) wen_hi++;
    if (brick_valid === 1'b1 && brick_ready === 1'b1 && nhs < 4) begin
      hs_cyc[nhs] = cyc + 1; nhs++;
    end
    if (prev_pending && (nm_wr_en !== 1'b1 || nm_wr_sel !== prev_sel ||
                         nm_wr_addr !== prev_addr)) unstable++;
    if (nm_wr_en === 1'b1 && enc_en !== 1'b1) unstable++;
    prev_pending = (nm_wr_en === 1'b1) && !nm_wr_ack;
    prev_sel     = nm_wr_sel;
    prev_addr    = nm_wr_addr;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; brick_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request; returns once the controller is back in IDLE (bounded).
  task automatic run_brick(input logic [11:0] a, input int dly, input logic ok);
    ack_delay = dly; enc_ok = ok;
    clear_mon();
    brick_addr = a; brick_valid = 1'b1;
    @(posedge clk); #1 brick_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (brick_ready === 1'b1 && (ndone > 0 || to_cyc >= 0)) break;
    end
    $display("brick addr=0x%03h ack_delay=%0d enc_ok=%0d: writes=%0d dones=%0d lat=%0d",
             a, dly, ok, nw, ndone, done_cyc[0] - hs_cyc[0]);
  endtask

  typedef struct {
    logic [11:0] addr;
    int          dly;
    int          lat;
    logic [11:0] off_addr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 12'h010, dly: 0, lat: 19, off_addr: 12'h110};
    vecs[1] = '{addr: 12'h3A5, dly: 3, lat: 25, off_addr: 12'h4A5};
    vecs[2] = '{addr: 12'hFC0, dly: 0, lat: 19, off_addr: 12'h0C0};
    vecs[3] = '{addr: 12'hFFF, dly: 1, lat: 21, off_addr: 12'h0FF};

    brick_addr = '0;
    clear_mon();
    do_reset();
    @(negedge clk);
    check("rst_brick_ready", 32'(brick_ready), 1);
    check("rst_busy",        32'(busy), 0);
    check("rst_enc_en",      32'(enc_en), 0);
    check("rst_nm_wr_en",    32'(nm_wr_en), 0);
    check("rst_nm_wr_sel",   32'(nm_wr_sel), 0);
    check("rst_nm_wr_addr",  32'(nm_wr_addr), 0);
    check("rst_done",        32'(done), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    @(posedge clk); #1;

    // Table-driven single-brick vectors.
    for (int v = 0; v < 4; v++) begin
      run_brick(vecs[v].addr, vecs[v].dly, 1'b1);
      check($sformatf("v%0d_handshakes", v), 32'(nhs), 1);
      check($sformatf("v%0d_writes", v),     32'(nw), 2);
      check($sformatf("v%0d_w0_sel", v),     32'(wsel[0]), 0);
      check($sformatf("v%0d_w0_addr", v),    32'(waddr[0]), 32'(vecs[v].addr));
      check($sformatf("v%0d_w1_sel", v),     32'(wsel[1]), 1);
      check($sformatf("v%0d_w1_addr", v),    32'(waddr[1]), 32'(vecs[v].off_addr));
      check($sformatf("v%0d_dones", v),      32'(ndone), 1);
      check($sformatf("v%0d_done_lat", v),   32'(done_cyc[0] - hs_cyc[0]), 32'(vecs[v].lat));
      check($sformatf("v%0d_enc_en_cycles", v), 32'(enc_hi), 32'(vecs[v].lat));
      check($sformatf("v%0d_wr_stable", v),  32'(unstable), 0);
      check($sformatf("v%0d_err_timeout", v), 32'(err_timeout), 0);
    end

    // Encoder never ready: abort after 20 ENCODE cycles.
    run_brick(12'h123, 0, 1'b0);
    check("to_writes",        32'(nw), 0);
    check("to_wr_en_cycles",  32'(wen_hi), 0);
    check("to_dones",         32'(ndone), 0);
    check("to_latency",       32'(to_cyc - hs_cyc[0]), 20);
    check("to_enc_en_cycles", 32'(enc_hi), 20);
    check("to_err_timeout",   32'(err_timeout), 1);
    check("to_back_idle",     32'(brick_ready), 1);

    // The error flag is sticky across a later successful brick.
    run_brick(12'h020, 0, 1'b1);
    check("sticky_done_lat",  32'(done_cyc[0] - hs_cyc[0]), 19);
    check("sticky_err",       32'(err_timeout), 1);
`ifdef ENC_CTRL_STATS_EN
    check("stat_bricks_5",    32'(stat_bricks), 5);
    check("stat_timeouts_1",  32'(stat_timeouts), 1);
`endif
    do_reset();
    @(negedge clk);
    check("err_cleared_by_rst", 32'(err_timeout), 0);
`ifdef ENC_CTRL_STATS_EN
    check("stat_bricks_rst",   32'(stat_bricks), 0);
    check("stat_timeouts_rst", 32'(stat_timeouts), 0);
`endif
    @(posedge clk); #1;

    // Reset while waiting for the value-brick acknowledge.
    clear_mon();
    ack_delay = 5; enc_ok = 1'b1;
    brick_addr = 12'h200; brick_valid = 1'b1;
    @(posedge clk); #1 brick_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (nm_wr_en === 1'b1) break;
      @(posedge clk); #1;
    end
    check("midrst_reached_wr_data", 32'(nm_wr_en), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("reset in WR_DATA: enc_en=%0d nm_wr_en=%0d brick_ready=%0d",
             enc_en, nm_wr_en, brick_ready);
    check("midrst_enc_en",      32'(enc_en), 0);
    check("midrst_nm_wr_en",    32'(nm_wr_en), 0);
    check("midrst_brick_ready", 32'(brick_ready), 1);
    check("midrst_done",        32'(done), 0);
    @(posedge clk); #1;
    run_brick(12'h055, 0, 1'b1);
    check("postrst_writes",   32'(nw), 2);
    check("postrst_w1_addr",  32'(waddr[1]), 32'h155);
    check("postrst_done_lat", 32'(done_cyc[0] - hs_cyc[0]), 19);

    // Back-to-back requests with brick_valid held high.
    do_reset();
    clear_mon();
    ack_delay = 0; enc_ok = 1'b1;
    brick_addr = 12'h0A0; brick_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ndone >= 2) break;
    end
    brick_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    $display("back-to-back: handshakes=%0d dones=%0d hs0=%0d hs1=%0d done0=%0d",
             nhs, ndone, hs_cyc[0], hs_cyc[1], done_cyc[0]);
    check("b2b_dones",        32'(ndone), 2);
    check("b2b_handshakes",   32'(nhs), 2);
    check("b2b_writes",       32'(nw), 4);
    check("b2b_hs_spacing",   32'(hs_cyc[1] - hs_cyc[0]), 21);
    check("b2b_after_done",   32'(hs_cyc[1] - done_cyc[0]), 2);
`ifdef ENC_CTRL_STATS_EN
    check("b2b_stat_bricks",  32'(stat_bricks), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
